// File: rtl/bitops_pkg.sv
// Shared definitions for the bit-serial stages: default word width, FSM state
// encoding and a constant-foldable ceiling-log2 helper.
package bitops_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_SHIFT  = 2'd0,
        ST_FULL   = 2'd1,
        ST_PARITY = 2'd2
    } state_e;

    // Never returns less than 1, so a counter declared with it has at least one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 1;
        for (int i = 1; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bit_deserializer.sv
// Serial-to-parallel converter, MSB first, with a double-buffered valid/ready word output.
// Optional trailing even-parity bit per word when BIT_DESER_PARITY_EN is defined.
module bit_deserializer
    import bitops_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready
`ifdef BIT_DESER_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam int unsigned CntW = clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             valid_q, valid_d;

    logic             accept;
    logic             slot_free;
    logic [WIDTH-1:0] shifted;

`ifdef BIT_DESER_PARITY_EN
    logic perr_pend_q, perr_pend_d;
    logic perr_out_q, perr_out_d;
    logic parity_fail;

    // In PARITY the shift register holds the complete data word.
    assign parity_fail = (^shreg_q) ^ bit_in;
    assign parity_err  = perr_out_q;
    assign bit_ready   = (state_q == ST_SHIFT) || (state_q == ST_PARITY);
`else
    assign bit_ready   = (state_q == ST_SHIFT);
`endif

    assign accept     = bit_valid && bit_ready;
    assign slot_free  = !valid_q || word_ready;
    assign shifted    = {shreg_q[WIDTH-2:0], bit_in};
    assign word_out   = word_q;
    assign word_valid = valid_q;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        valid_d = valid_q;
`ifdef BIT_DESER_PARITY_EN
        perr_pend_d = perr_pend_q;
        perr_out_d  = perr_out_q;
`endif

        // Drain first; a load below in the same cycle overrides it.
        if (valid_q && word_ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            ST_SHIFT: begin
                if (accept) begin
                    shreg_d = shifted;
                    if (cnt_q == LastCnt) begin
                        cnt_d = '0;
`ifdef BIT_DESER_PARITY_EN
                        state_d = ST_PARITY;
`else
                        if (slot_free) begin
                            word_d  = shifted;
                            valid_d = 1'b1;
                        end else begin
                            state_d = ST_FULL;
                        end
`endif
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end

            ST_FULL: begin
                if (slot_free) begin
                    word_d  = shreg_q;
                    valid_d = 1'b1;
                    state_d = ST_SHIFT;
`ifdef BIT_DESER_PARITY_EN
                    perr_out_d = perr_pend_q;
`endif
                end
            end

`ifdef BIT_DESER_PARITY_EN
            ST_PARITY: begin
                if (accept) begin
                    if (slot_free) begin
                        word_d     = shreg_q;
                        valid_d    = 1'b1;
                        perr_out_d = parity_fail;
                        state_d    = ST_SHIFT;
                    end else begin
                        perr_pend_d = parity_fail;
                        state_d     = ST_FULL;
                    end
                end
            end
`endif

            default: begin
                state_d = ST_SHIFT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_SHIFT;
            shreg_q <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
`ifdef BIT_DESER_PARITY_EN
            perr_pend_q <= 1'b0;
            perr_out_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            valid_q <= valid_d;
`ifdef BIT_DESER_PARITY_EN
            perr_pend_q <= perr_pend_d;
            perr_out_q  <= perr_out_d;
`endif
        end
    end

endmodule

// File: tb/tb_bit_deserializer.sv
// Self-checking bench for bit_deserializer: directed scenarios plus random traffic
// checked every cycle against a queue-based model of completed words.
module tb_bit_deserializer;
    import bitops_pkg::*;

    localparam int unsigned W = DEFAULT_WIDTH;
`ifdef BIT_DESER_PARITY_EN
    localparam int unsigned GroupLen = W + 1;
`else
    localparam int unsigned GroupLen = W;
`endif

    typedef struct {
        logic [W-1:0] w;
        logic         pe;
    } word_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         bit_in;
    logic         bit_valid;
    logic         bit_ready;
    logic [W-1:0] word_out;
    logic         word_valid;
    logic         word_ready;
    logic         parity_err;

    int checks = 0;
    int errors = 0;

    word_t  exp_q[$];
    logic   pbits[$];
    logic [W-1:0] last_w;
    logic         last_pe;

    always #5 clk = ~clk;

    bit_deserializer #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready)
`ifdef BIT_DESER_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

`ifndef BIT_DESER_PARITY_EN
    assign parity_err = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        pbits.delete();
        last_w  = '0;
        last_pe = 1'b0;
    endtask

    // Compare outputs with the model, drive one cycle, then advance the model.
    task automatic tick(input logic bv, input logic b, input logic wr, input logic r);
        logic  exp_ready;
        logic  accept;
        logic  consume;
        word_t nw;
        logic  x;

        exp_ready = (exp_q.size() < 2);
        check("bit_ready", 32'(bit_ready), 32'(exp_ready));
        check("word_valid", 32'(word_valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            check("word_out", 32'(word_out), 32'(exp_q[0].w));
            check("parity_err", 32'(parity_err), 32'(exp_q[0].pe));
        end else begin
            check("word_out_held", 32'(word_out), 32'(last_w));
            check("parity_err_held", 32'(parity_err), 32'(last_pe));
        end

        rst        = r;
        bit_valid  = bv;
        bit_in     = b;
        word_ready = wr;
        accept     = bv && exp_ready;
        consume    = wr && (exp_q.size() > 0);

        @(posedge clk);
        #1;

        if (r) begin
            model_clear();
        end else begin
            if (consume) begin
                nw      = exp_q.pop_front();
                last_w  = nw.w;
                last_pe = nw.pe;
            end
            if (accept) begin
                pbits.push_back(b);
                if (pbits.size() == GroupLen) begin
                    nw.w = '0;
                    x    = 1'b0;
                    for (int i = 0; i < int'(GroupLen); i++) begin
                        x = x ^ pbits[i];
                        if (i < int'(W)) nw.w = {nw.w[W-2:0], pbits[i]};
                    end
`ifdef BIT_DESER_PARITY_EN
                    nw.pe = x;
`else
                    nw.pe = 1'b0;
`endif
                    exp_q.push_back(nw);
                    pbits.delete();
                end
            end
        end
    endtask

    // Send n bits from vec, most significant of the n first, one per cycle.
    task automatic send(input logic [15:0] vec, input int n, input logic wr);
        for (int i = n - 1; i >= 0; i--) begin
            tick(1'b1, vec[i], wr, 1'b0);
        end
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst        = 1'b1;
        bit_valid  = 1'b0;
        bit_in     = 1'b0;
        word_ready = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        check("reset_bit_ready", 32'(bit_ready), 32'd1);
        check("reset_word_valid", 32'(word_valid), 32'd0);
        check("reset_word_out", 32'(word_out), 32'd0);
        check("reset_parity_err", 32'(parity_err), 32'd0);

`ifndef BIT_DESER_PARITY_EN
        // Single word, consumer always ready: valid for exactly one cycle.
        do_reset();
        send(16'b1011, 4, 1'b1);
        check("t1_word", 32'(word_out), 32'hB);
        check("t1_valid", 32'(word_valid), 32'd1);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        check("t1_valid_drop", 32'(word_valid), 32'd0);
        check("t1_word_held", 32'(word_out), 32'hB);

        // Back-to-back words with no bubble.
        do_reset();
        send(16'b1100, 4, 1'b1);
        check("t2_word0", 32'(word_out), 32'hC);
        send(16'b0101, 4, 1'b1);
        check("t2_word1", 32'(word_out), 32'h5);
        check("t2_ready", 32'(bit_ready), 32'd1);

        // Back-pressure: second word parks in the shift register.
        do_reset();
        send(16'b1011_0110, 8, 1'b0);
        check("t3_full_ready", 32'(bit_ready), 32'd0);
        check("t3_held_word", 32'(word_out), 32'hB);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        check("t3_second_word", 32'(word_out), 32'h6);
        check("t3_ready_back", 32'(bit_ready), 32'd1);
        tick(1'b0, 1'b0, 1'b1, 1'b0);

        // Idle gaps between bits.
        do_reset();
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        check("t4_no_early_valid", 32'(word_valid), 32'd0);
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        check("t4_word", 32'(word_out), 32'h6);

        // Reset mid-word leaves no residue.
        do_reset();
        send(16'b11, 2, 1'b1);
        do_reset();
        send(16'b1001, 4, 1'b1);
        check("t5_word", 32'(word_out), 32'h9);
        check("t5_valid", 32'(word_valid), 32'd1);
`else
        do_reset();
        send(16'b1011_1, 5, 1'b1);
        check("p1_word", 32'(word_out), 32'hB);
        check("p1_perr", 32'(parity_err), 32'd0);
        send(16'b1011_0, 5, 1'b1);
        check("p2_word", 32'(word_out), 32'hB);
        check("p2_perr", 32'(parity_err), 32'd1);
        check("p2_valid", 32'(word_valid), 32'd1);
`endif

        // Random traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            tick(($urandom_range(0, 9) < 7), 1'($urandom), ($urandom_range(0, 9) < 5),
                 ($urandom_range(0, 199) == 0));
        end
        for (int i = 0; i < 200; i++) begin
            tick(1'b1, 1'($urandom), 1'b1, 1'b0);
        end
        tick(1'b0, 1'b0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bit_deserializer.md
Name: bit_deserializer

Overview:
- Serial-to-parallel converter that assembles WIDTH serial bits into one word and presents it on a valid/ready output port.
- Sits directly upstream of the bit reverser stage; word_out feeds its data_in.
- Double-buffered: a shift register collects the next word while the output register waits for the consumer.

Parameters:
WIDTH, 4, word width in bits (>= 2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
bit_in  input  1  serial data bit
bit_valid  input  1  bit_in is valid this cycle
bit_ready  output  1  block accepts bit_in this cycle
word_out  output  WIDTH  assembled word, MSB = first bit received
word_valid  output  1  word_out holds an unconsumed word
word_ready  input  1  consumer accepts word_out this cycle

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: word_out=0, word_valid=0, bit_ready=1 (comb: state==SHIFT), internal shift register=0, bit count=0, state=SHIFT.
- Bit accept: bit_valid && bit_ready at a rising edge. Shift order is MSB-first: shreg <= {shreg[WIDTH-2:0], bit_in}.
- Count: width clog2(WIDTH). It increments on each accept and wraps to 0 on the WIDTH-th accept.
- Output slot is free when word_valid==0 || word_ready==1.
- States:
  - SHIFT: collecting bits; bit_ready=1.
  - FULL: shreg holds a complete word and the output slot was busy; bit_ready=0.
- Transitions:
  - SHIFT, WIDTH-th accept, slot free: word_out <= {shreg[WIDTH-2:0], bit_in}; word_valid <= 1; stay in SHIFT.
  - SHIFT, WIDTH-th accept, slot busy: shreg holds the word; go to FULL.
  - FULL, slot free: word_out <= shreg; word_valid <= 1; go to SHIFT.
- Latency: word_valid rises the cycle after the edge that accepts the last bit, when the slot is free.
- Output handshake:
  - word_valid && word_ready with no new word loading → word_valid <= 0. word_out is held; it is not cleared.
  - Simultaneous drain and load → word_valid stays 1 and word_out updates. Back-to-back words need zero bubbles.
- Stability: word_out is stable while word_valid && !word_ready.
- bit_valid=0 inserts a gap; partial count and shreg are held.
- Reset mid-word discards the partial word and any pending output.
- Sustained throughput: 1 bit/cycle with word_ready held 1.

Optional Feature:
- Macro: BIT_DESER_PARITY_EN.
- When defined:
  - Each word is followed by one even-parity bit (XOR of data bits and parity bit = 0). This adds state PARITY, entered after the WIDTH-th data bit.
  - The parity bit is accepted under the same bit_valid/bit_ready handshake.
  - The word is transferred to the output only after the parity bit is accepted, so latency counts from the parity accept.
  - Added output port parity_err (1 bit, reset 0) is registered with word_out: 1 if the parity check failed. It follows the word_valid/word_ready rules.
  - The word is still delivered on a parity error.
- When undefined: no PARITY state, no parity_err port, behaviour as above.

Decomposition:
- Shared package bitops_pkg:
  - state encoding constants ST_SHIFT, ST_FULL, ST_PARITY
  - function clog2 used for the count width
  - the bit reverser and this block both use the WIDTH default from it (DEFAULT_WIDTH=4)
- No sub-module: single module with an FSM plus shift, count and output registers.
- Integration: top level instantiates bit_deserializer → bit_reverser.

Test Plan:
- Reset, then bits 1,0,1,1 with word_ready=1 → word_out=4'b1011, word_valid=1 for exactly one cycle, the cycle after the 4th accept.
- Continuous 8 bits 1,1,0,0,0,1,0,1 with word_ready=1 → words 4'b1100 then 4'b0101, bit_ready never drops.
- word_ready=0, send 8 bits → first word 4'b1011 held stable; after the second word completes, state FULL and bit_ready=0. Raise word_ready → 4'b1011 consumed, then the second word appears the next cycle and bit_ready returns to 1.
- bit_valid gaps (bits 0, idle 3 cycles, 1, 1, idle, 0) → word_out=4'b0110 and count unaffected by idle cycles.
- Assert rst after 2 bits, then send 1,0,0,1 → word_out=4'b1001 and no residue from the aborted word.
- With BIT_DESER_PARITY_EN: data 1,0,1,1 + parity 1 → parity_err=0. The same data with parity 0 → parity_err=1 and word_out=4'b1011.
